// File: rtl/counter_sequencer.sv
// Round-robin sequencer that shares one up counter among N_REQ requesters:
// loads the winner's start value, paces increments and pulses finish at terminal count.
module counter_sequencer #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned CW       = 3,
    parameter int unsigned STEP_DIV = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req_i,
    input  logic [N_REQ*CW-1:0] start_val_i,
    output logic [N_REQ-1:0]    gnt_o,
    output logic [N_REQ-1:0]    finish_o,
    output logic                busy_o,
    output logic                ctr_load_o,
    output logic [CW-1:0]       ctr_in_o,
    output logic                ctr_inc_o,
    input  logic                ctr_done_i
);

    localparam int unsigned PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned PRESC_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(STEP_DIV - 1);
    localparam logic [PTR_W-1:0]   PTR_LAST   = PTR_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   finish_q, finish_d;
    logic               busy_q, busy_d;
    logic               ctr_load_q, ctr_load_d;
    logic [CW-1:0]      start_q, start_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PRESC_W-1:0] presc_q, presc_d;

    logic               arb_found_c;
    logic [PTR_W-1:0]   arb_idx_c;
    logic               win_req_c;
    logic               presc_last_c;

    // Round-robin search starting at ptr_q and wrapping past N_REQ-1.
    always_comb begin : arb_p
        int unsigned cand;
        arb_found_c = 1'b0;
        arb_idx_c   = '0;
        cand        = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = 32'(ptr_q) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!arb_found_c && req_i[PTR_W'(cand)]) begin
                arb_found_c = 1'b1;
                arb_idx_c   = PTR_W'(cand);
            end
        end
    end

    assign win_req_c    = |(req_i & gnt_q);
    assign presc_last_c = (presc_q == PRESC_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            gnt_q      <= '0;
            finish_q   <= '0;
            busy_q     <= 1'b0;
            ctr_load_q <= 1'b0;
            start_q    <= '0;
            ptr_q      <= '0;
            presc_q    <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            finish_q   <= finish_d;
            busy_q     <= busy_d;
            ctr_load_q <= ctr_load_d;
            start_q    <= start_d;
            ptr_q      <= ptr_d;
            presc_q    <= presc_d;
        end
    end

    // Next state; a dropped winner request beats ctr_done in the same cycle.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        start_d   = start_q;
        ptr_d     = ptr_q;
        presc_d   = presc_q;
        ctr_inc_o = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (arb_found_c) begin
                    state_d = S_LOAD;
                    gnt_d   = N_REQ'(1) << arb_idx_c;
                    start_d = start_val_i[32'(arb_idx_c) * CW +: CW];
                    ptr_d   = (arb_idx_c == PTR_LAST) ? '0 : arb_idx_c + PTR_W'(1);
                end
            end
            S_LOAD: begin
                presc_d = '0;
                if (!win_req_c) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                ctr_inc_o = presc_last_c && !ctr_done_i && win_req_c;
                presc_d   = presc_last_c ? '0 : presc_q + PRESC_W'(1);
                if (!win_req_c) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                end else if (ctr_done_i) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase

        busy_d     = (state_d != S_IDLE);
        ctr_load_d = (state_d == S_LOAD);
        finish_d   = (state_d == S_DONE) ? gnt_d : '0;
    end

    assign gnt_o      = gnt_q;
    assign finish_o   = finish_q;
    assign busy_o     = busy_q;
    assign ctr_load_o = ctr_load_q;
    assign ctr_in_o   = start_q;

    a_gnt_onehot: assert property (@(posedge clock) disable iff (!reset) $onehot0(gnt_q));
    a_load_inc_excl: assert property (@(posedge clock) disable iff (!reset) !(ctr_load_q && ctr_inc_o));
    a_no_inc_at_done: assert property (@(posedge clock) disable iff (!reset) !(ctr_done_i && ctr_inc_o));

endmodule
